// File: rtl/viterbi_feed_ctrl.sv
// Soft-pair FIFO feeding the Viterbi decoder with flush-pair injection, plus the decoded-bit
// skip/pack path. Define VIT_FEED_STATS_EN to add the transfer and byte statistics outputs.
module viterbi_feed_ctrl #(
    parameter int SOFT_W      = 3,
    parameter int FIFO_DEPTH  = 16,
    parameter int CNT_W       = 20,
    parameter int FLUSH_PAIRS = 48,
    parameter int FLUSH_VAL   = 3,
    parameter int SKIP_BITS   = 9
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        start,
    input  logic                        do_descramble,
    input  logic [CNT_W-1:0]            num_pairs,
    input  logic [2*SOFT_W-1:0]         in_data,
    input  logic [1:0]                  in_erase,
    input  logic                        in_valid,
    output logic [SOFT_W-1:0]           vit_data0,
    output logic [SOFT_W-1:0]           vit_data1,
    output logic [1:0]                  vit_erase,
    output logic                        vit_tvalid,
    input  logic                        vit_tready,
    input  logic                        conv_bit,
    input  logic                        conv_valid,
    input  logic                        descr_bit,
    input  logic                        descr_valid,
    output logic [7:0]                  byte_out,
    output logic                        byte_out_strobe,
    output logic                        feed_done,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef VIT_FEED_STATS_EN
    ,
    output logic [CNT_W-1:0]            stat_pairs_fed,
    output logic [15:0]                 stat_bytes_out
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 2 * SOFT_W + 2;
    localparam int FW = (FLUSH_PAIRS > 1) ? $clog2(FLUSH_PAIRS) : 1;
    localparam int SW = (SKIP_BITS > 0) ? $clog2(SKIP_BITS + 1) : 1;

    localparam logic [LW-1:0]     FULL_LVL   = LW'(FIFO_DEPTH);
    localparam logic [FW-1:0]     FLUSH_LAST = FW'(FLUSH_PAIRS - 1);
    localparam logic [SW-1:0]     SKIP_INIT  = SW'(SKIP_BITS);
    localparam logic [SOFT_W-1:0] FLUSH_SOFT = SOFT_W'(FLUSH_VAL);

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_FLUSH, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_pairs_q, num_pairs_d;
    logic               descr_q, descr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               valid_q, valid_d;
    logic [SOFT_W-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic [1:0]         erase_q, erase_d;
    logic [CNT_W-1:0]   pair_cnt_q, pair_cnt_d;
    logic [FW-1:0]      flush_cnt_q, flush_cnt_d;
    logic [SW-1:0]      skip_q, skip_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [6:0]         shreg_q, shreg_d;
    logic [7:0]         byte_q, byte_d;
    logic               strobe_q, strobe_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
`ifdef VIT_FEED_STATS_EN
    logic [CNT_W-1:0]   stat_pairs_q, stat_pairs_d;
    logic [15:0]        stat_bytes_q, stat_bytes_d;
`endif

    logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]      fifo_head;
    logic               fifo_we;
    logic               xfer, pop, push;
    logic [CNT_W-1:0]   pair_next;
    logic               bit_v, bit_in;

    assign fifo_head = fifo_mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (enable && fifo_we) begin
            fifo_mem[wr_ptr_q] <= {in_erase, in_data};
        end
    end

    always_comb begin
        state_d     = state_q;
        num_pairs_d = num_pairs_q;
        descr_d     = descr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        valid_d     = valid_q;
        data0_d     = data0_q;
        data1_d     = data1_q;
        erase_d     = erase_q;
        pair_cnt_d  = pair_cnt_q;
        flush_cnt_d = flush_cnt_q;
        skip_d      = skip_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        byte_d      = byte_q;
        strobe_d    = strobe_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
`ifdef VIT_FEED_STATS_EN
        stat_pairs_d = stat_pairs_q;
        stat_bytes_d = stat_bytes_q;
`endif
        fifo_we   = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        xfer      = valid_q & enable & vit_tready;
        pair_next = pair_cnt_q + 1'b1;
        bit_v     = descr_q ? descr_valid : conv_valid;
        bit_in    = descr_q ? descr_bit : conv_bit;

        if (start) begin
            state_d     = (num_pairs == '0) ? S_FLUSH : S_PASS;
            num_pairs_d = num_pairs;
            descr_d     = do_descramble;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            valid_d     = 1'b0;
            pair_cnt_d  = '0;
            flush_cnt_d = '0;
            skip_d      = do_descramble ? SKIP_INIT : '0;
            bit_cnt_d   = '0;
            shreg_d     = '0;
            strobe_d    = 1'b0;
            done_d      = 1'b0;
            ovf_d       = 1'b0;
`ifdef VIT_FEED_STATS_EN
            stat_pairs_d = '0;
            stat_bytes_d = '0;
`endif
        end else begin
`ifdef VIT_FEED_STATS_EN
            if (xfer) stat_pairs_d = stat_pairs_q + 1'b1;
`endif
            case (state_q)
                S_PASS: begin
                    // Refill the output register whenever it is empty or being consumed.
                    pop  = (!valid_q || xfer) && (level_q != '0);
                    push = in_valid && ((level_q != FULL_LVL) || pop);
                    if (in_valid && !push) ovf_d = 1'b1;
                    if (xfer) pair_cnt_d = pair_next;
                    if (xfer && (pair_next == num_pairs_q)) begin
                        state_d  = S_FLUSH;
                        valid_d  = 1'b1;
                        data0_d  = FLUSH_SOFT;
                        data1_d  = FLUSH_SOFT;
                        erase_d  = 2'b00;
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        level_d  = '0;
                    end else begin
                        if (pop) begin
                            data0_d  = fifo_head[SOFT_W-1:0];
                            data1_d  = fifo_head[2*SOFT_W-1:SOFT_W];
                            erase_d  = fifo_head[EW-1:2*SOFT_W];
                            valid_d  = 1'b1;
                            rd_ptr_d = rd_ptr_q + 1'b1;
                        end else if (xfer) begin
                            valid_d = 1'b0;
                        end
                        if (push) begin
                            fifo_we  = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                        level_d = level_q + LW'(push) - LW'(pop);
                    end
                end
                S_FLUSH: begin
                    valid_d = 1'b1;
                    data0_d = FLUSH_SOFT;
                    data1_d = FLUSH_SOFT;
                    erase_d = 2'b00;
                    if (xfer) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_d = S_DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            flush_cnt_d = flush_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            if (state_q != S_IDLE) begin
                strobe_d = 1'b0;
                if (bit_v) begin
                    if (skip_q != '0) begin
                        skip_d = skip_q - 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_d   = {bit_in, shreg_q};
                            strobe_d = 1'b1;
`ifdef VIT_FEED_STATS_EN
                            if (stat_bytes_q != 16'hFFFF) stat_bytes_d = stat_bytes_q + 1'b1;
`endif
                        end else begin
                            shreg_d[bit_cnt_q] = bit_in;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            num_pairs_q <= '0;
            descr_q     <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            data0_q     <= '0;
            data1_q     <= '0;
            erase_q     <= '0;
            pair_cnt_q  <= '0;
            flush_cnt_q <= '0;
            skip_q      <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            byte_q      <= '0;
            strobe_q    <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef VIT_FEED_STATS_EN
            stat_pairs_q <= '0;
            stat_bytes_q <= '0;
`endif
        end else if (enable) begin
            state_q     <= state_d;
            num_pairs_q <= num_pairs_d;
            descr_q     <= descr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            erase_q     <= erase_d;
            pair_cnt_q  <= pair_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            skip_q      <= skip_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            byte_q      <= byte_d;
            strobe_q    <= strobe_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
`ifdef VIT_FEED_STATS_EN
            stat_pairs_q <= stat_pairs_d;
            stat_bytes_q <= stat_bytes_d;
`endif
        end
    end

    assign vit_data0       = data0_q;
    assign vit_data1       = data1_q;
    assign vit_erase       = erase_q;
    assign vit_tvalid      = valid_q & enable;
    assign byte_out        = byte_q;
    assign byte_out_strobe = strobe_q;
    assign feed_done       = done_q;
    assign overflow        = ovf_q;
    assign fifo_level      = level_q;
`ifdef VIT_FEED_STATS_EN
    assign stat_pairs_fed  = stat_pairs_q;
    assign stat_bytes_out  = stat_bytes_q;
`endif

endmodule

// File: tb/tb_viterbi_feed_ctrl.sv
// Bench for viterbi_feed_ctrl: packer vector table, directed feed/flush/overflow/reset
// sequences, and randomized runs checked against a stream-level model.
`timescale 1ns/1ps
module tb_viterbi_feed_ctrl;
    localparam int SOFT_W      = 3;
    localparam int FIFO_DEPTH  = 16;
    localparam int CNT_W       = 20;
    localparam int FLUSH_PAIRS = 48;
    localparam int FLUSH_VAL   = 3;
    localparam int SKIP_BITS   = 9;
    localparam int LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2*SOFT_W+1:0] FLUSH_WORD = {2'b00, SOFT_W'(FLUSH_VAL), SOFT_W'(FLUSH_VAL)};

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b1;
    logic start = 1'b0;
    logic do_descramble = 1'b0;
    logic [CNT_W-1:0] num_pairs = '0;
    logic [2*SOFT_W-1:0] in_data = '0;
    logic [1:0] in_erase = '0;
    logic in_valid = 1'b0;
    logic [SOFT_W-1:0] vit_data0, vit_data1;
    logic [1:0] vit_erase;
    logic vit_tvalid;
    logic vit_tready = 1'b0;
    logic conv_bit = 1'b0, conv_valid = 1'b0, descr_bit = 1'b0, descr_valid = 1'b0;
    logic [7:0] byte_out;
    logic byte_out_strobe, feed_done, overflow;
    logic [LW-1:0] fifo_level;
`ifdef VIT_FEED_STATS_EN
    logic [CNT_W-1:0] stat_pairs_fed;
    logic [15:0] stat_bytes_out;
`endif

    viterbi_feed_ctrl #(
        .SOFT_W(SOFT_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W),
        .FLUSH_PAIRS(FLUSH_PAIRS), .FLUSH_VAL(FLUSH_VAL), .SKIP_BITS(SKIP_BITS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
        .do_descramble(do_descramble), .num_pairs(num_pairs),
        .in_data(in_data), .in_erase(in_erase), .in_valid(in_valid),
        .vit_data0(vit_data0), .vit_data1(vit_data1), .vit_erase(vit_erase),
        .vit_tvalid(vit_tvalid), .vit_tready(vit_tready),
        .conv_bit(conv_bit), .conv_valid(conv_valid),
        .descr_bit(descr_bit), .descr_valid(descr_valid),
        .byte_out(byte_out), .byte_out_strobe(byte_out_strobe),
        .feed_done(feed_done), .overflow(overflow), .fifo_level(fifo_level)
`ifdef VIT_FEED_STATS_EN
        , .stat_pairs_fed(stat_pairs_fed), .stat_bytes_out(stat_bytes_out)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] bytes_q[$];
    logic hold_prev = 1'b0;
    logic [7:0] hold_data = '0;

    typedef struct {
        logic       descr;
        logic [15:0] bits;
        logic [7:0] b0;
        logic [7:0] b1;
    } vec_t;

    // Transfers and bytes are sampled mid-cycle; a held beat must not change.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && vit_tvalid) begin
                checks++;
                if ({vit_erase, vit_data1, vit_data0} !== hold_data) begin
                    errors++;
                    $display("FAIL hold_stable got %h want %h", {vit_erase, vit_data1, vit_data0}, hold_data);
                end
            end
            if (vit_tvalid && vit_tready) got_q.push_back({vit_erase, vit_data1, vit_data0});
            if (byte_out_strobe) bytes_q.push_back(byte_out);
            hold_prev = vit_tvalid && !vit_tready;
            hold_data = {vit_erase, vit_data1, vit_data0};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic d);
        start = 1'b1;
        num_pairs = n;
        do_descramble = d;
        tick();
        start = 1'b0;
        got_q.delete();
        bytes_q.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!feed_done && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_done"}, feed_done, 1);
    endtask

    task automatic cmp_stream(input string name, input logic [7:0] exp_q[$]);
        chk({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_beat%0d got %h want %h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic set_bits(input logic d, input logic b);
        conv_valid  = 1'b1;
        descr_valid = 1'b1;
        conv_bit    = d ? ~b : b;
        descr_bit   = d ? b : ~b;
    endtask

    task automatic clear_bits();
        conv_valid = 1'b0;
        descr_valid = 1'b0;
    endtask

    initial begin
        vec_t tbl[4];
        logic [5:0] t1 [4];
        logic [7:0] exp_q[$];
        logic sel_q[$];
        logic [3:0] pat;

        tbl[0] = '{descr: 1'b0, bits: 16'hAA01, b0: 8'h01, b1: 8'hAA};
        tbl[1] = '{descr: 1'b1, bits: 16'hAA01, b0: 8'h01, b1: 8'hAA};
        tbl[2] = '{descr: 1'b0, bits: 16'h5AC3, b0: 8'hC3, b1: 8'h5A};
        tbl[3] = '{descr: 1'b1, bits: 16'h0FF0, b0: 8'hF0, b1: 8'h0F};
        t1[0] = 6'h1A; t1[1] = 6'h2B; t1[2] = 6'h3C; t1[3] = 6'h05;

        // Reset values
        #12;
        chk("rst_tvalid", vit_tvalid, 0);
        chk("rst_done", feed_done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_data", {vit_erase, vit_data1, vit_data0}, 0);
        #10 reset_n = 1'b1;
        tick();

        // Basic feed + flush, with first-beat latency
        do_start(4, 1'b0);
        vit_tready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data = t1[i];
            in_erase = 2'b00;
            exp_q.push_back({2'b00, t1[i]});
            tick();
            if (i == 0) chk("lat_edge_t", vit_tvalid, 0);
            if (i == 1) chk("lat_edge_t1", vit_tvalid, 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < FLUSH_PAIRS; i++) exp_q.push_back(FLUSH_WORD);
        wait_done("t1", 400);
        cmp_stream("t1", exp_q);
        chk("t1_tvalid_done", vit_tvalid, 0);

        // Backpressure pattern 1,0,0,1 with 6 pairs
        do_start(6, 1'b0);
        pat = 4'b1001;
        exp_q.delete();
        for (int c = 0; c < 600 && !feed_done; c++) begin
            vit_tready = pat[c % 4];
            in_valid = (c < 6);
            if (c < 6) begin
                in_data = 6'($urandom);
                in_erase = 2'($urandom);
                exp_q.push_back({in_erase, in_data});
            end
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < FLUSH_PAIRS; i++) exp_q.push_back(FLUSH_WORD);
        chk("t2_done", feed_done, 1);
        cmp_stream("t2", exp_q);

        // Overflow with decoder stalled
        do_start(20, 1'b0);
        vit_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data = 6'(i);
            tick();
        end
        chk("t3_ovf_17", overflow, 0);
        chk("t3_level_17", fifo_level, 16);
        tick();
        chk("t3_ovf_18", overflow, 1);
        chk("t3_level_18", fifo_level, 16);
        vit_tready = 1'b1;
        tick();
        chk("t3_full_pop_level", fifo_level, 16);
        vit_tready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("t3_ovf_sticky", overflow, 1);
        do_start(3, 1'b0);
        chk("t3_ovf_cleared", overflow, 0);
        chk("t3_level_cleared", fifo_level, 0);

        // Enable gating of tvalid while flushing
        do_start(0, 1'b0);
        tick();
        chk("en_tvalid_on", vit_tvalid, 1);
        enable = 1'b0;
        #1 chk("en_tvalid_gated", vit_tvalid, 0);
        enable = 1'b1;
        #1 chk("en_tvalid_back", vit_tvalid, 1);

        // Packer vector table (decoder stalled in FLUSH)
        foreach (tbl[v]) begin
            do_start(0, tbl[v].descr);
            vit_tready = 1'b0;
            if (tbl[v].descr) begin
                for (int k = 0; k < SKIP_BITS; k++) begin
                    set_bits(1'b1, 1'($urandom));
                    tick();
                end
            end
            for (int i = 0; i < 16; i++) begin
                set_bits(tbl[v].descr, tbl[v].bits[i]);
                tick();
                if (i == 7) begin
                    chk($sformatf("pk%0d_strobe", v), byte_out_strobe, 1);
                    chk($sformatf("pk%0d_b0_now", v), byte_out, tbl[v].b0);
                end
            end
            clear_bits();
            tick(); tick(); tick();
            chk($sformatf("pk%0d_count", v), bytes_q.size(), 2);
            if (bytes_q.size() >= 2) begin
                chk($sformatf("pk%0d_b0", v), bytes_q[0], tbl[v].b0);
                chk($sformatf("pk%0d_b1", v), bytes_q[1], tbl[v].b1);
            end
        end

        // Zero data pairs: straight to flush
        do_start(0, 1'b0);
        vit_tready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < FLUSH_PAIRS; i++) exp_q.push_back(FLUSH_WORD);
        wait_done("t5", 300);
        cmp_stream("t5", exp_q);

        // Randomized runs against the stream-level model
        for (int it = 0; it < 8; it++) begin
            int n, total, pushed, cyc;
            logic d;
            n = $urandom_range(1, 10);
            d = 1'($urandom_range(0, 1));
            total = n + $urandom_range(0, 3);
            do_start(CNT_W'(n), d);
            exp_q.delete();
            sel_q.delete();
            pushed = 0;
            cyc = 0;
            while (!(feed_done && pushed == total) && cyc < 1500) begin
                in_valid = (pushed < total) && ($urandom_range(0, 2) != 0);
                if (in_valid) begin
                    in_data = 6'($urandom);
                    in_erase = 2'($urandom);
                    if (pushed < n) exp_q.push_back({in_erase, in_data});
                    pushed++;
                end
                vit_tready = ($urandom_range(0, 3) != 0);
                conv_valid = 1'($urandom); conv_bit = 1'($urandom);
                descr_valid = 1'($urandom); descr_bit = 1'($urandom);
                if (d ? descr_valid : conv_valid) sel_q.push_back(d ? descr_bit : conv_bit);
                tick();
                cyc++;
            end
            in_valid = 1'b0;
            clear_bits();
            tick(); tick();
            chk($sformatf("rnd%0d_done", it), feed_done, 1);
            for (int i = 0; i < FLUSH_PAIRS; i++) exp_q.push_back(FLUSH_WORD);
            cmp_stream($sformatf("rnd%0d", it), exp_q);
            if (d) for (int k = 0; k < SKIP_BITS && sel_q.size() > 0; k++) void'(sel_q.pop_front());
            chk($sformatf("rnd%0d_nbytes", it), bytes_q.size(), sel_q.size() / 8);
            for (int b = 0; b < sel_q.size() / 8 && b < bytes_q.size(); b++) begin
                logic [7:0] eb;
                for (int j = 0; j < 8; j++) eb[j] = sel_q[b * 8 + j];
                chk($sformatf("rnd%0d_byte%0d", it, b), bytes_q[b], eb);
            end
        end

        // Asynchronous reset in FLUSH, then in_valid ignored until start
        do_start(0, 1'b0);
        vit_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_bits(1'b0, 1'b1);
            tick();
        end
        clear_bits();
        #2 reset_n = 1'b0;
        #1;
        chk("ar_tvalid", vit_tvalid, 0);
        chk("ar_data", {vit_erase, vit_data1, vit_data0}, 0);
        chk("ar_byte", byte_out, 0);
        chk("ar_done", feed_done, 0);
        chk("ar_level", fifo_level, 0);
        tick();
        #2 reset_n = 1'b1;
        got_q.delete();
        tick();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data = 6'($urandom);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("ar_idle_xfers", got_q.size(), 0);
        chk("ar_idle_level", fifo_level, 0);
        chk("ar_idle_tvalid", vit_tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
